// File: rtl/bubble_sort_ctrl.sv
// Sequencing FSM for a top-down bubble-sort datapath: walks compare/swap passes,
// stops after the first pass with no exchange, and frames each job with EOC pulses.
module bubble_sort_ctrl #(
  parameter int N      = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gt,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              swap_en,
  output logic              clear_eoc,
  output logic              preset_eoc,
  output logic              busy,
  output logic [ADDR_W-1:0] pass_idx
);

  typedef enum logic [2:0] {IDLE, START, CMP, SWAP, ADV, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 2);

  state_t            state, state_n;
  logic [ADDR_W-1:0] i, j, i_n, j_n;
  logic              swapped, swapped_n;
  logic              end_of_pass;

  assign end_of_pass = (j == LAST - i);

  always_comb begin
    state_n   = state;
    i_n       = i;
    j_n       = j;
    swapped_n = swapped;
    case (state)
      IDLE: if (start) state_n = START;
      START: begin
        i_n       = '0;
        j_n       = '0;
        swapped_n = 1'b0;
        state_n   = CMP;
      end
      CMP:  state_n = gt ? SWAP : ADV;
      SWAP: begin
        swapped_n = 1'b1;
        state_n   = ADV;
      end
      ADV: begin
        if (!end_of_pass) begin
          j_n     = j + ADDR_W'(1);
          state_n = CMP;
        end else if (!swapped || i == LAST) begin
          state_n = DONE;
        end else begin
          i_n       = i + ADDR_W'(1);
          j_n       = '0;
          swapped_n = 1'b0;
          state_n   = CMP;
        end
      end
      // Counters return to zero so IDLE always presents addr_a=0, addr_b=1.
      DONE: begin
        i_n       = '0;
        j_n       = '0;
        swapped_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values, so they align with the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      swapped    <= 1'b0;
      swap_en    <= 1'b0;
      clear_eoc  <= 1'b0;
      preset_eoc <= 1'b0;
      busy       <= 1'b0;
      addr_b     <= ADDR_W'(1);
    end else begin
      state      <= state_n;
      i          <= i_n;
      j          <= j_n;
      swapped    <= swapped_n;
      swap_en    <= (state_n == SWAP);
      clear_eoc  <= (state_n == START);
      preset_eoc <= (state_n == DONE);
      busy       <= (state_n != IDLE);
      addr_b     <= j_n + ADDR_W'(1);
    end
  end

  assign addr_a   = j;
  assign pass_idx = i;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboard bench: a loop-level bubble-sort model predicts swaps, job length and final
// array; per-size monitors compare DUT events against the queued expectations.
module tb_bubble_sort_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input int n, input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL N=%0d %s: got %0d expected %0d", n, name, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int N  = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    localparam int AW = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

    logic          rst, start, gt, swap_en, clear_eoc, preset_eoc, busy;
    logic [AW-1:0] addr_a, addr_b, pass_idx;
    logic [7:0]    mem [N];
    logic [63:0]   load_val;
    logic          load_req = 1'b0;
    int            cyc = 0;
    bit            abort_mode = 1'b0;
    bit            post_done = 1'b0;
    bit            fin = 1'b0;

    int          exp_clear_q[$];
    int          exp_swap_q[$];
    int          exp_done_q[$];
    logic [63:0] exp_arr_q[$];

    bubble_sort_ctrl #(.N(N), .ADDR_W(AW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .gt(gt),
      .addr_a(addr_a), .addr_b(addr_b), .swap_en(swap_en),
      .clear_eoc(clear_eoc), .preset_eoc(preset_eoc), .busy(busy),
      .pass_idx(pass_idx)
    );

    // Register-array datapath the controller sequences.
    assign gt = (mem[addr_a] > mem[addr_b]);

    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (load_req) begin
        for (int k = 0; k < N; k++) mem[k] <= load_val[8*k +: 8];
      end else if (swap_en) begin
        mem[addr_a] <= mem[addr_b];
        mem[addr_b] <= mem[addr_a];
      end
    end

    function automatic logic [63:0] pack_mem();
      logic [63:0] v = '0;
      for (int k = 0; k < N; k++) v[8*k +: 8] = mem[k];
      return v;
    endfunction

    // Reference: plain bubble sort with early exit; 2 cycles per compare, 3 if swapped.
    task automatic model(input logic [63:0] arr, output int d, output logic [63:0] res);
      logic [7:0] a [N];
      logic [7:0] t;
      int c;
      bit sw;
      for (int k = 0; k < N; k++) a[k] = arr[8*k +: 8];
      c = 1;
      for (int i = 0; i <= N - 2; i++) begin
        sw = 1'b0;
        for (int j = 0; j <= N - 2 - i; j++) begin
          if (a[j] > a[j+1]) begin
            t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            exp_swap_q.push_back(i * 256 + j);
            c += 3;
            sw = 1'b1;
          end else begin
            c += 2;
          end
        end
        if (!sw) break;
      end
      d = c + 1;
      res = '0;
      for (int k = 0; k < N; k++) res[8*k +: 8] = a[k];
    endtask

    task automatic load(input logic [63:0] v);
      @(negedge clk);
      load_val = v;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
    endtask

    task automatic run_job(input logic [63:0] arr, input bit noisy);
      int d, c0, t;
      logic [63:0] res;
      load(arr);
      model(arr, d, res);
      @(negedge clk);
      c0 = cyc;
      exp_clear_q.push_back(c0 + 1);
      exp_done_q.push_back(c0 + d);
      exp_arr_q.push_back(res);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 2; k < d; k++) begin
        @(negedge clk);
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (exp_done_q.size() != 0 && t < 4 * N * N + 40) begin
        @(negedge clk);
        t++;
      end
      if (exp_done_q.size() != 0) begin
        check(N, "job completion timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_done_q.delete();
        exp_arr_q.delete();
      end
      @(negedge clk);
      @(negedge clk);
      check(N, "swaps left unconsumed", exp_swap_q.size(), 0);
      check(N, "clear_eoc left unconsumed", exp_clear_q.size(), 0);
      exp_swap_q.delete();
      exp_clear_q.delete();
    endtask

    task automatic run_abort(input logic [63:0] arr, input int ab);
      int c0;
      load(arr);
      @(negedge clk);
      c0 = cyc;
      exp_clear_q.push_back(c0 + 1);
      abort_mode = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + ab) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check(N, "abort busy", busy, 0);
      check(N, "abort addr_a", addr_a, 0);
      check(N, "abort addr_b", addr_b, 1);
      check(N, "abort preset_eoc", preset_eoc, 0);
      check(N, "abort swap_en", swap_en, 0);
      rst = 1'b0;
      abort_mode = 1'b0;
      repeat (2 * N * N + 10) @(negedge clk);
      check(N, "abort clear_eoc unconsumed", exp_clear_q.size(), 0);
      exp_clear_q.delete();
    endtask

    always @(negedge clk) begin
      int e;
      if (!rst) begin
        if (post_done) begin
          check(N, "idle busy after done", busy, 0);
          check(N, "idle addr_a after done", addr_a, 0);
          check(N, "idle addr_b after done", addr_b, 1);
          post_done = 1'b0;
        end
        if (clear_eoc) begin
          if (exp_clear_q.size() == 0) check(N, "unexpected clear_eoc", 1, 0);
          else begin
            check(N, "clear_eoc cycle", cyc, exp_clear_q.pop_front());
            check(N, "busy with clear_eoc", busy, 1);
          end
        end
        if (swap_en && !abort_mode) begin
          if (exp_swap_q.size() == 0) check(N, "unexpected swap_en", 1, 0);
          else begin
            e = exp_swap_q.pop_front();
            check(N, "swap pass_idx", pass_idx, e / 256);
            check(N, "swap addr_a", addr_a, e % 256);
            check(N, "swap addr_b", addr_b, e % 256 + 1);
          end
        end
        if (preset_eoc) begin
          if (exp_done_q.size() == 0) check(N, "unexpected preset_eoc", 1, 0);
          else begin
            check(N, "preset_eoc cycle", cyc, exp_done_q.pop_front());
            check(N, "final array", pack_mem(), exp_arr_q.pop_front());
            check(N, "clear with preset", clear_eoc, 0);
            check(N, "busy in done", busy, 1);
            post_done = 1'b1;
          end
        end
      end
    end

    initial begin
      logic [63:0] asc, rev, early, rnd;
      asc = '0; rev = '0;
      for (int k = 0; k < N; k++) begin
        asc[8*k +: 8] = 8'(k + 1);
        rev[8*k +: 8] = 8'(N - k);
      end
      early = asc;
      early[7:0]  = asc[15:8];
      early[15:8] = asc[7:0];
      rst = 1'b1;
      start = 1'b0;
      load(asc);
      @(negedge clk);
      check(N, "reset swap_en", swap_en, 0);
      check(N, "reset clear_eoc", clear_eoc, 0);
      check(N, "reset preset_eoc", preset_eoc, 0);
      check(N, "reset busy", busy, 0);
      check(N, "reset addr_a", addr_a, 0);
      check(N, "reset addr_b", addr_b, 1);
      check(N, "reset pass_idx", pass_idx, 0);
      rst = 1'b0;
      run_job(asc, 1'b0);
      run_job(rev, 1'b0);
      run_job(early, 1'b0);
      run_job(rev, 1'b1);
      run_abort(rev, (N > 2) ? 6 : 3);
      run_job(rev, 1'b0);
      for (int r = 0; r < 20; r++) begin
        rnd = '0;
        for (int k = 0; k < N; k++) rnd[8*k +: 8] = 8'($urandom_range(0, 15));
        run_job(rnd, 1'($urandom_range(0, 1)));
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) check(0, "bench completion timeout", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

Sequencing FSM for the top-down bubble-sort datapath. On `start` it runs compare/swap passes over an N-entry register array. It drives the element addresses and the swap strobe, and terminates early once a pass completes with no swap. It clears the end-of-conversion register at job start and presets it at job end, through the `clear_eoc`/`preset_eoc` pulses.

## Interface
- `N`, 8: number of elements sorted; legal range N ≥ 2.
- `ADDR_W`, 3: address width; must satisfy 2^ADDR_W ≥ N.
- `clk`  in  1  system clock, all state changes on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  begin a sort job; sampled only in IDLE.
- `gt`  in  1  datapath comparator, combinational: mem[addr_a] > mem[addr_b].
- `addr_a`  out  ADDR_W  left element index j.
- `addr_b`  out  ADDR_W  right element index j+1.
- `swap_en`  out  1  datapath exchanges mem[addr_a] and mem[addr_b] at the end of this cycle.
- `clear_eoc`  out  1  one-cycle pulse to the EOC register at job start.
- `preset_eoc`  out  1  one-cycle pulse to the EOC register at job end.
- `busy`  out  1  high in every state except IDLE.
- `pass_idx`  out  ADDR_W  current pass i.

## Operation
- Internal state: counters `i`, `j` (ADDR_W bits each) and flag `swapped`.
- All outputs are Moore outputs, decoded from state and registered counters.
- `addr_a` = j and `addr_b` = j+1 in every state. In IDLE, j = 0.
- States and transitions:
  - IDLE: when `start` = 1, go to START. Otherwise stay.
  - START: `clear_eoc` = 1. Load i=0, j=0, swapped=0. Go to CMP.
  - CMP: if `gt` = 1, go to SWAP. Else go to ADV.
  - SWAP: `swap_en` = 1. Set swapped=1. Go to ADV.
  - ADV, case j ≠ N-2-i: increment j, go to CMP.
  - ADV, case j = N-2-i (end of pass), swapped=0 or i=N-2: go to DONE.
  - ADV, case j = N-2-i (end of pass), otherwise: increment i, set j=0, clear swapped, go to CMP.
  - DONE: `preset_eoc` = 1. Go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `clear_eoc` and `preset_eoc` are never high in the same cycle.
- `gt` is only used in CMP.
- Counters never wrap. j ≤ N-2 and i ≤ N-2 hold at all times.

## Timing
- Reset: state=IDLE, i=j=swapped=0.
- Reset values of all outputs: `swap_en`, `clear_eoc`, `preset_eoc`, `busy` = 0; `addr_a` = 0, `addr_b` = 1, `pass_idx` = 0.
- Reset mid-job aborts immediately; the next cycle is IDLE with no `preset_eoc`.
- `start` sampled at edge 0: START occupies cycle 1 and `busy` rises in cycle 1.
- Per compare: 2 cycles with no swap (CMP, ADV), 3 cycles with a swap (CMP, SWAP, ADV).
- The pass containing the final compare is followed by DONE for one cycle. `busy` falls in the cycle after DONE.
- Total job cycles = 1 (START) + Σ(compare costs) + 1 (DONE).
- Datapath contract:
  - `gt` must be valid in the CMP cycle, from the current array contents.
  - The swap commits on the edge ending SWAP and is visible by the next CMP.
- `start` held high continuously retriggers a new job in the cycle after returning to IDLE.

## Test plan
- **Sorted input:** N=4, array [1,2,3,4], `start` pulse.
  - `clear_eoc` in cycle 1.
  - 3 compares, no `swap_en`.
  - `preset_eoc` in cycle 8; final array unchanged.
- **Reverse input:** N=4, array [4,3,2,1].
  - 6 `swap_en` pulses; `pass_idx` takes values 0, 1, 2.
  - `preset_eoc` in cycle 20; final array [1,2,3,4].
- **Early termination:** N=4, array [2,1,3,4].
  - 1 swap (pass 0, j=0), then a clean pass 1.
  - `preset_eoc` in cycle 13; `pass_idx` never reaches 2.
- **Minimum size:** N=2, array [9,5].
  - Sequence START, CMP, SWAP, ADV, DONE.
  - `preset_eoc` in cycle 5; final array [5,9].
- **Abort:** `rst` high in cycle 6 of the reverse-input job.
  - Next cycle: IDLE, `busy` = 0, `addr_a` = 0, `preset_eoc` never asserted.
  - A new `start` runs a full job correctly.
- **Ignored start:** `start` pulsed repeatedly during a busy job.
  - No extra `clear_eoc` pulse and no change in cycle count versus the same job run alone.
